// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        PRESSED,
        CHK_REL
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

endpackage

// File: rtl/btn_debouncer_sync_2ff.sv
// Two-flop synchronizer bringing one asynchronous bit into the i_clk domain.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/btn_debouncer.sv
// Push-button debouncer: accepts a level change only after DEBOUNCE_CYCLES
// consecutive identical synchronized samples, with press/release strobes.
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_btn_level,
    output logic o_btn_pulse,
    output logic o_btn_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic s_btn;

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_btn),
        .o_q     (s_btn)
    );

    // The first differing sample already counts as 1, so acceptance happens
    // on the sample that would take the count to N.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_btn) begin
                    state_d = CHK_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHK_PRESS: begin
                if (!s_btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_btn) begin
                    state_d = CHK_REL;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHK_REL: begin
                if (s_btn) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == CHK_REL);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    assign o_btn_level   = level_q;
    assign o_btn_pulse   = pulse_q;
    assign o_btn_release = release_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Scoreboard bench for btn_debouncer with DEBOUNCE_CYCLES=4.
module tb_btn_debouncer;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic level;
    logic pulse;
    logic rel;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    btn_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_btn         (btn),
        .o_btn_level   (level),
        .o_btn_pulse   (pulse),
        .o_btn_release (rel)
    );

    typedef struct {
        bit is_press;
        int cycle;
    } evt_t;

    evt_t exp_q[$];
    evt_t cur_evt;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_press   = 0;
    int   n_rel     = 0;
    int   exp_press = 0;
    int   exp_rel   = 0;
    bit   last_press = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic v, output int e);
        @(negedge clk);
        btn = v;
        e = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic at_edge(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic expect_evt(input bit p, input int c);
        exp_q.push_back('{p, c});
        if (p) exp_press++;
        else   exp_rel++;
    endtask

    // Monitor: every strobe pops the scoreboard and is checked for kind and cycle.
    always @(negedge clk) begin
        if (pulse || rel) begin
            $display("[TB] cycle %0d press=%0d release=%0d level=%0d", cyc, pulse, rel, level);
            check("no_simultaneous_strobes", int'(pulse && rel), 0);
            if (pulse) n_press++;
            if (rel)   n_rel++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_cycle", cyc, -1);
            end else begin
                cur_evt = exp_q.pop_front();
                check("strobe_kind_is_press", int'(pulse), int'(cur_evt.is_press));
                check("strobe_cycle", cyc, cur_evt.cycle);
            end
            if (pulse) begin
                check("press_after_release", int'(last_press), 0);
                last_press = 1'b1;
            end
            if (rel) begin
                check("release_after_press", int'(last_press), 1);
                last_press = 1'b0;
            end
        end else if (rst) begin
            last_press = 1'b0;
        end
    end

    initial begin
        int e;
        int e2;
        int pat[5];
        pat = '{1, 0, 1, 0, 1};
        rst = 1'b1;
        btn = 1'b0;

        // Reset state
        idle(3);
        check("reset_level", int'(level), 0);
        check("reset_pulse", int'(pulse), 0);
        check("reset_release", int'(rel), 0);
        rst = 1'b0;
        idle(3);

        // Clean press and release
        drive(1'b1, e);
        expect_evt(1'b1, e + N + 1);
        at_edge(e + N);
        check("clean_level_before_accept", int'(level), 0);
        at_edge(e + N + 1);
        check("clean_level_after_accept", int'(level), 1);
        at_edge(e + 19);
        drive(1'b0, e);
        expect_evt(1'b0, e + N + 1);
        at_edge(e + N);
        check("clean_rel_level_before", int'(level), 1);
        at_edge(e + N + 1);
        check("clean_rel_level_after", int'(level), 0);
        idle(10);

        // Bounce 1,0,1,0,1 then held
        for (int i = 0; i < 5; i++) drive(pat[i] != 0, e);
        expect_evt(1'b1, e + N + 1);
        at_edge(e + N);
        check("bounce_level_before", int'(level), 0);
        at_edge(e + N + 1);
        check("bounce_level_after", int'(level), 1);
        idle(15);
        drive(1'b0, e);
        expect_evt(1'b0, e + N + 1);
        idle(15);

        // Glitch of N-1 samples is ignored
        drive(1'b1, e);
        idle(2);
        drive(1'b0, e2);
        at_edge(e + N + 1);
        check("glitch_level_mid", int'(level), 0);
        idle(10);
        check("glitch_level_end", int'(level), 0);

        // Shortest accepted press: exactly N samples high
        drive(1'b1, e);
        idle(3);
        drive(1'b0, e2);
        expect_evt(1'b1, e + N + 1);
        expect_evt(1'b0, e2 + N + 1);
        at_edge(e + N + 1);
        check("min_press_level", int'(level), 1);
        at_edge(e2 + N + 1);
        check("min_press_released", int'(level), 0);
        idle(10);

        // Ten press/release cycles
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, e);
            expect_evt(1'b1, e + N + 1);
            idle(9);
            drive(1'b0, e);
            expect_evt(1'b0, e + N + 1);
            idle(9);
        end
        idle(10);

        // Reset in the middle of a press count, button still held
        drive(1'b1, e);
        at_edge(e + 2);
        rst = 1'b1;
        at_edge(e + 3);
        check("midreset_level", int'(level), 0);
        check("midreset_pulse", int'(pulse), 0);
        check("midreset_release", int'(rel), 0);
        rst = 1'b0;
        expect_evt(1'b1, e + 4 + N + 1);
        at_edge(e + 4 + N);
        check("midreset_level_before", int'(level), 0);
        at_edge(e + 4 + N + 1);
        check("midreset_level_after", int'(level), 1);
        idle(10);

        // Reset while pressed: level drops, no release strobe
        @(negedge clk);
        rst = 1'b1;
        btn = 1'b0;
        e = cyc + 1;
        at_edge(e);
        check("pressed_reset_level", int'(level), 0);
        check("pressed_reset_pulse", int'(pulse), 0);
        check("pressed_reset_release", int'(rel), 0);
        rst = 1'b0;
        idle(15);
        check("pressed_reset_level_after", int'(level), 0);

        idle(5);
        check("scoreboard_drained", exp_q.size(), 0);
        check("press_count", n_press, exp_press);
        check("release_count", n_rel, exp_rel);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, number of consecutive stable sampled cycles (N) needed to accept a level change; legal range N >= 2.
REQ-002 SHALL have port i_clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port i_btn, input, 1, raw asynchronous, bouncing push-button level (1 = pressed).
REQ-005 SHALL have port o_btn_level, output, 1, debounced button level.
REQ-006 SHALL have port o_btn_pulse, output, 1, one-cycle strobe on each accepted press; this is the increment enable for the downstream press counter.
REQ-007 SHALL have port o_btn_release, output, 1, one-cycle strobe on each accepted release.

Function
REQ-008 SHALL pass i_btn through a two-flop synchronizer; the second flop output is s_btn; no other logic SHALL read i_btn.
REQ-009 SHALL implement states IDLE (level 0, stable), CHK_PRESS, PRESSED (level 1, stable), CHK_REL.
REQ-010 SHALL, in IDLE, on s_btn=1 go to CHK_PRESS with cnt=1; otherwise hold with cnt=0.
REQ-011 SHALL, in CHK_PRESS, on s_btn=1 increment cnt; when cnt==N-1 and s_btn=1, go to PRESSED, clear cnt, and assert o_btn_pulse for exactly the one following cycle.
REQ-012 SHALL, in CHK_PRESS, on s_btn=0 return to IDLE with cnt=0 and no output change.
REQ-013 SHALL apply REQ-010..012 symmetrically to PRESSED/CHK_REL with s_btn=0 as the changing value; acceptance returns to IDLE and asserts o_btn_release for one cycle.
REQ-014 SHALL drive o_btn_level=1 in PRESSED and CHK_REL, 0 in IDLE and CHK_PRESS, registered.
REQ-015 SHALL give latency: if i_btn is first sampled 1 at edge E0 and held, o_btn_level and o_btn_pulse go high after edge E0+N+1; release latency is identical.
REQ-016 SHALL ignore any bounce run shorter than N sampled cycles: no strobe, no level change.
REQ-017 SHALL never assert o_btn_pulse and o_btn_release in the same cycle, and SHALL never emit two presses without an intervening release.
REQ-018 SHALL size cnt at $clog2(N) bits; cnt SHALL never exceed N-1 and SHALL not wrap.
REQ-019 SHALL treat a button held through reset deassertion as a new press (pulse after N+1 edges from the first post-reset edge that samples it).

Reset
REQ-020 SHALL, while i_reset=1 at a clock edge, force state IDLE, cnt=0, both synchronizer flops 0, o_btn_level=0, o_btn_pulse=0, o_btn_release=0.
REQ-021 SHALL, on reset mid-CHK_PRESS or mid-CHK_REL, discard the partial count and emit no strobe.

Structure
REQ-022 SHALL place the state typedef (enum IDLE/CHK_PRESS/PRESSED/CHK_REL) and default DEBOUNCE_CYCLES constant in shared package btn_pkg.
REQ-023 SHALL instantiate the synchronizer as sub-module sync_2ff (1-bit, reset to 0); all else in btn_debouncer.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-024 Clean press: i_btn 0->1 sampled at E0, held 20 cycles -> o_btn_pulse high exactly one cycle after edge E0+5; o_btn_level=1 from E0+5.
REQ-025 Bounce: i_btn toggles 1,0,1,0,1 one cycle each, then held 1 -> no pulse during toggling; single pulse 5 edges after the final sampled rising edge.
REQ-026 Glitch: i_btn high for 3 cycles then low -> o_btn_pulse, o_btn_level, o_btn_release stay 0.
REQ-027 Press/release x10 (10 cycles high, 10 low) -> exactly 10 pulses and 10 releases, alternating.
REQ-028 Reset mid-count: i_btn high, i_reset pulsed 1 cycle at E0+3 -> all outputs 0; with i_btn still high, pulse 5 edges after first post-reset sampling edge.
REQ-029 Reset while PRESSED -> o_btn_level drops to 0 at the reset edge, no o_btn_release strobe.
